key_step_debouncer: RTL



---
 rtl/key_ctrl_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/key_step_debouncer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared key-control types, timing constants and helpers
package key_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Board timing at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  // Shortened timing for simulation
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_PERIOD   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_debouncer.sv
// rtl/key_step_debouncer.sv - debounces one push-button into a single-cycle step strobe
module key_step_debouncer
  import key_ctrl_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic step,
  output logic key_level,
  output logic busy
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic          KEY_IDLE  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DB    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_DELAY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] CNT_PER   = CW'(REPEAT_PERIOD - 1);

  logic          key_sync;
  logic          pressed;
  key_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          rep_started, rep_started_d;
  logic          step_d, level_d, busy_d;

  sync_2ff #(.RST_VAL(KEY_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_sync)
  );

  assign pressed = (ACTIVE_LOW != 0) ? ~key_sync : key_sync;

  // State, shared counter and registered outputs; reset discards all progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rep_started <= 1'b0;
      step        <= 1'b0;
      key_level   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rep_started <= rep_started_d;
      step        <= step_d;
      key_level   <= level_d;
      busy        <= busy_d;
    end
  end

  // Next-state logic; rep_started selects first-delay versus period compare in HELD
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    rep_started_d = rep_started;
    step_d        = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_DB) begin
          state_d       = HELD;
          cnt_d         = '0;
          rep_started_d = 1'b0;
          step_d        = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if (REPEAT_EN != 0) begin
          if (cnt == (rep_started ? CNT_PER : CNT_DELAY)) begin
            step_d        = 1'b1;
            cnt_d         = '0;
            rep_started_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d       = HELD;
          cnt_d         = '0;
          rep_started_d = 1'b0;
        end else if (cnt == CNT_DB) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

endmodule
